// File: rtl/sseg_serial_driver.sv
// Serial seven-segment frame driver.
// Converts eight hex nibbles (with decimal-point and blink masks) into an
// active-low 64-bit segment frame, shifts it MSB first into an external
// shift-register chain, then strobes the storage latch.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : one-shot frame request (sampled only when idle)
//   auto_refresh   : restart a frame automatically after each one completes
//   disp_num       : eight hex digits, digit 7 = [31:28]
//   point_in       : per-digit decimal point enable
//   blink_in       : per-digit blink enable
//   seg_clk        : serial shift clock (receiver samples on rising edge)
//   seg_sout       : serial data, MSB first
//   seg_latch      : storage-register latch strobe
//   busy           : high from frame capture to end of latch phase
//   done           : one-cycle pulse on the last latch cycle
module sseg_serial_driver #(
  parameter int unsigned DIV     = 2,
  parameter int unsigned BLINK_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        auto_refresh,
  input  logic [31:0] disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  blink_in,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_latch,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BIT_CYC = 2 * DIV;
  localparam int unsigned CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        frame_q, frame_d;
  logic [BLINK_W-1:0] blink_cnt_q;

  logic seg_clk_d, seg_sout_d, seg_latch_d, busy_d, done_d;

  // Active-low {dp,g,f,e,d,c,b,a} code for one hex digit
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  // Full frame; blanking during the blink phase overrides the point
  function automatic logic [63:0] build_frame(input logic [31:0] num,
                                              input logic [7:0]  pt,
                                              input logic [7:0]  bl,
                                              input logic        phase);
    logic [63:0] f;
    logic [7:0]  b;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      b = hex_to_seg(num[4*i +: 4]);
      if (pt[i]) b[7] = 1'b0;
      if (bl[i] && phase) b = 8'hFF;
      f[8*i +: 8] = b;
    end
    return f;
  endfunction

  // Free-running blink counter
  always_ff @(posedge clk) begin
    if (rst) blink_cnt_q <= '0;
    else     blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
  end

  // Next-state and next-output logic; outputs are decoded from the next state
  // so that the registered outputs line up with the state they describe
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (start || auto_refresh) begin
          state_d = SHIFT;
          idx_d   = 6'd63;
          cnt_d   = '0;
          frame_d = build_frame(disp_num, point_in, blink_in,
                                blink_cnt_q[BLINK_W-1]);
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == 6'd0) state_d = LATCH;
          else               idx_d   = idx_q - 6'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LATCH: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    seg_clk_d   = (state_d == SHIFT) && (cnt_d >= CNT_HALF);
    seg_sout_d  = (state_d == SHIFT) && frame_d[idx_d];
    seg_latch_d = (state_d == LATCH);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == LATCH) && (cnt_d == CNT_LAST);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      frame_q   <= '0;
      seg_clk   <= 1'b0;
      seg_sout  <= 1'b0;
      seg_latch <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      seg_clk   <= seg_clk_d;
      seg_sout  <= seg_sout_d;
      seg_latch <= seg_latch_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
